cache_miss_controller: RTL and testbench
========================================

Name: cache_miss_controller

Overview:
- Sequences the 2-way, 8-set, 256-bit-line write-back cache between the CPU port and main memory.
- Accepts one CPU load or store at a time and issues the cache lookup.
- On a miss: writes back the dirty victim line, fetches the missing line, fills it into the cache, then replays the original access.
- Sits between the CPU load/store interface, the cache array block and the line-wide memory port.

Parameters:
- ADDR_W, 32, byte address width. Tag = [31:8], set = [7:5], offset = [4:0].
- LINE_W, 256, cache line and memory beat width in bits.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting with error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cpu_valid  in  1  CPU request present; held with stable inputs until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store word
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load result, valid while cpu_ready=1
- cpu_err  out  1  completion carries an error; qualified by cpu_ready
- cache_re  out  1  cache read lookup strobe
- cache_we  out  1  cache word write strobe
- cache_fill  out  1  write cache_fill_data and tag into the LRU way, clear dirty
- cache_addr  out  32  address for the cache operation
- cache_wdata  out  32  word for cache_we
- cache_fill_data  out  256  line for cache_fill
- cache_rdata  in  32  word read, valid the cycle after cache_re
- cache_miss  in  1  registered hit/miss result, valid the cycle after cache_re or cache_we
- victim_dirty  in  1  LRU way of the addressed set is dirty; valid with cache_miss
- victim_tag  in  24  tag of the LRU way; valid with cache_miss
- victim_line  in  256  data of the LRU way; valid with cache_miss
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line write, 0 = line read
- mem_addr  out  32  line-aligned address, bits [4:0] = 0
- mem_wdata  out  256  write-back line
- mem_rdata  in  256  fetched line, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset, asynchronous on reset=0:
  - State returns to IDLE from any state; any in-flight memory transaction is abandoned.
  - Reset value 0 on every output and on all internal registers: latched request, captured victim, fetched line, timeout counter, retry flag.
  - mem_req drops immediately on reset assertion.
- State machine: IDLE, LOOKUP, WRITEBACK, FETCH, FILL, DONE.
- IDLE:
  - The request is accepted in the cycle cpu_valid=1; addr, we and wdata are latched.
  - cache_re (load) or cache_we (store) is driven combinationally in that same cycle, using cpu_addr and cpu_wdata.
  - Next state is LOOKUP.
- LOOKUP:
  - Sample cache_miss. On cache_miss=0, capture cache_rdata and go to DONE.
  - On cache_miss=1 with victim_dirty=1: capture victim_tag and victim_line, go to WRITEBACK.
  - On cache_miss=1 with victim_dirty=0: go to FETCH.
  - If cache_miss=1 while the retry flag is set, go to DONE with the error flag set.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr={victim_tag, set, 5'b0}, mem_wdata=victim_line.
  - Hold all of these until mem_ack, then go to FETCH.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr={tag, set, 5'b0}. On mem_ack, register mem_rdata and go to FILL.
- Timeout:
  - A counter resets on entry to WRITEBACK or FETCH and increments each cycle without mem_ack.
  - When it reaches TIMEOUT, drop mem_req, set the error flag and go to DONE.
  - mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success.
- FILL:
  - Drive cache_fill=1 for exactly one cycle, with cache_addr = latched addr and cache_fill_data = fetched line.
  - Set the retry flag and go back to the replay step.
- Replay:
  - Reissue the latched cache_re or cache_we for one cycle, then go to LOOKUP.
  - Replay is an unnamed sub-cycle of FILL→LOOKUP: FILL lasts 2 cycles, fill then reissue.
- DONE:
  - cpu_ready=1 for one cycle; cpu_rdata = captured word for loads, 0 for stores; cpu_err = error flag.
  - Clear the retry and error flags, go to IDLE.
- Latency:
  - Hit: ready 2 cycles after acceptance.
  - Clean miss: 2 + Tfetch + 4 cycles.
  - Dirty miss additionally adds Twb.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after cpu_ready. cpu_valid outside IDLE is ignored.
- mem_ack outside WRITEBACK or FETCH is ignored.
- Only one of cache_re, cache_we and cache_fill is asserted in any cycle.

Test Plan:
- Reset, then load 0x0000_0040 with the cache modelling a hit and rdata 0xDEAD_BEEF → cpu_ready in cycle 2, cpu_rdata=0xDEAD_BEEF, cpu_err=0, no mem_req.
- Clean load miss at 0x0000_1020 with memory acking after 3 cycles:
  - One FETCH with mem_addr=0x0000_1020 and mem_we=0.
  - cache_fill pulses once, the replayed lookup hits, cpu_ready arrives at cycle 9.
- Dirty store miss at 0x0000_2064, victim_tag=0x000011:
  - WRITEBACK with mem_addr=0x0000_1160 and mem_wdata=victim_line precedes FETCH of 0x0000_2060.
  - The store is replayed with cache_we, then cpu_ready=1.
- Memory never acks in FETCH → mem_req drops after 255 cycles; cpu_ready=1 and cpu_err=1 for one cycle; next request accepted.
- Reset pulsed mid-WRITEBACK → mem_req=0 asynchronously; all outputs 0; IDLE; a subsequent hit completes normally.
- Replayed lookup still reports miss → cpu_ready=1 with cpu_err=1, no second FETCH.

Source files
------------

// File: rtl/cache_miss_controller_if.sv
// Signal bundle between the miss controller and its CPU port, cache array and line-wide memory port.
interface cache_miss_controller_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;

    logic              cache_re;
    logic              cache_we;
    logic              cache_fill;
    logic [ADDR_W-1:0] cache_addr;
    logic [31:0]       cache_wdata;
    logic [LINE_W-1:0] cache_fill_data;
    logic [31:0]       cache_rdata;
    logic              cache_miss;
    logic              victim_dirty;
    logic [ADDR_W-9:0] victim_tag;
    logic [LINE_W-1:0] victim_line;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    // master is the controller; slave is the CPU, cache array and memory surrounding it
    modport master (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_err,
        output cache_re, cache_we, cache_fill, cache_addr, cache_wdata, cache_fill_data,
        input  cache_rdata, cache_miss, victim_dirty, victim_tag, victim_line,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_err,
        input  cache_re, cache_we, cache_fill, cache_addr, cache_wdata, cache_fill_data,
        output cache_rdata, cache_miss, victim_dirty, victim_tag, victim_line,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cache_miss_controller.sv
// Miss sequencer for the 2-way write-back cache: lookup, victim write-back, line fetch, fill, replay.
// IDLE accept | LOOKUP hit/miss | WRITEBACK victim out | FETCH line in | FILL fill then replay | DONE cpu_ready
module cache_miss_controller #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    cache_miss_controller_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_FETCH, S_FILL, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-9:0]   vtag_q, vtag_d;
    logic [LINE_W-1:0]   vline_q, vline_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                retry_q, retry_d;
    logic                err_q, err_d;
    logic                replay_q, replay_d;
    logic                expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            vtag_q   <= '0;
            vline_q  <= '0;
            line_q   <= '0;
            cnt_q    <= '0;
            retry_q  <= 1'b0;
            err_q    <= 1'b0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            vtag_q   <= vtag_d;
            vline_q  <= vline_d;
            line_q   <= line_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
            replay_q <= replay_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        vtag_d   = vtag_q;
        vline_d  = vline_q;
        line_d   = line_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        err_d    = err_q;
        replay_d = replay_q;

        bus.cpu_ready       = 1'b0;
        bus.cpu_rdata       = '0;
        bus.cpu_err         = 1'b0;
        bus.cache_re        = 1'b0;
        bus.cache_we        = 1'b0;
        bus.cache_fill      = 1'b0;
        bus.cache_addr      = '0;
        bus.cache_wdata     = '0;
        bus.cache_fill_data = '0;
        bus.mem_req         = 1'b0;
        bus.mem_we          = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_wdata       = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_valid) begin
                    addr_d          = bus.cpu_addr;
                    we_d            = bus.cpu_we;
                    wdata_d         = bus.cpu_wdata;
                    rdata_d         = '0;
                    bus.cache_re    = !bus.cpu_we;
                    bus.cache_we    = bus.cpu_we;
                    bus.cache_addr  = bus.cpu_addr;
                    bus.cache_wdata = bus.cpu_wdata;
                    state_d         = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!bus.cache_miss) begin
                    rdata_d = bus.cache_rdata;
                    state_d = S_DONE;
                end else if (retry_q) begin
                    // the freshly filled line still misses: give up rather than loop
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (bus.victim_dirty) begin
                    vtag_d  = bus.victim_tag;
                    vline_d = bus.victim_line;
                    cnt_d   = '0;
                    state_d = S_WRITEBACK;
                end else begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {vtag_q, addr_q[7:5], 5'b0};
                bus.mem_wdata = vline_q;
                if (bus.mem_ack) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[ADDR_W-1:5], 5'b0};
                if (bus.mem_ack) begin
                    line_d  = bus.mem_rdata;
                    state_d = S_FILL;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FILL: begin
                bus.cache_addr = addr_q;
                if (!replay_q) begin
                    bus.cache_fill      = 1'b1;
                    bus.cache_fill_data = line_q;
                    retry_d             = 1'b1;
                    replay_d            = 1'b1;
                end else begin
                    bus.cache_re    = !we_q;
                    bus.cache_we    = we_q;
                    bus.cache_wdata = wdata_q;
                    replay_d        = 1'b0;
                    state_d         = S_LOOKUP;
                end
            end
            S_DONE: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_rdata = we_q ? 32'd0 : rdata_q;
                bus.cpu_err   = err_q;
                retry_d       = 1'b0;
                err_d         = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_miss_controller.sv
// Randomised bench for cache_miss_controller: scripted cache/memory responders plus a per-request latency/traffic model.
module tb_cache_miss_controller;
    localparam int TIMEOUT = 255;
    localparam int NEVER   = 1000;
    localparam int BUDGET  = 700;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  rd1;
        logic [31:0]  rd2;
        logic         hit;
        logic         dirty;
        logic         replay_hit;
        logic [23:0]  vtag;
        logic [255:0] vline;
        logic [255:0] line;
        int           wb_delay;
        int           fetch_delay;
    } txn_t;

    logic clk_i = 1'b0;
    logic reset_ni;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    cache_miss_controller_if bus ();

    cache_miss_controller dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic any_out();
        return bus.cpu_ready | (|bus.cpu_rdata) | bus.cpu_err | bus.cache_re | bus.cache_we |
               bus.cache_fill | (|bus.cache_addr) | (|bus.cache_wdata) | (|bus.cache_fill_data) |
               bus.mem_req | bus.mem_we | (|bus.mem_addr) | (|bus.mem_wdata);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we          = 1'($urandom_range(0, 1));
        t.addr        = $urandom;
        t.wdata       = $urandom;
        t.rd1         = $urandom;
        t.rd2         = $urandom;
        t.hit         = ($urandom_range(0, 99) < 40);
        t.dirty       = 1'($urandom_range(0, 1));
        t.replay_hit  = ($urandom_range(0, 99) < 85);
        t.vtag        = 24'($urandom);
        t.vline       = rand_line();
        t.line        = rand_line();
        t.wb_delay    = $urandom_range(0, 6);
        t.fetch_delay = $urandom_range(0, 6);
        return t;
    endfunction

    task automatic drive_garbage();
        bus.cache_miss   = 1'($urandom);
        bus.cache_rdata  = $urandom;
        bus.victim_dirty = 1'($urandom);
        bus.victim_tag   = 24'($urandom);
        bus.victim_line  = rand_line();
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = rand_line();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            bus.cpu_valid = 1'b0;
            bus.cpu_addr  = $urandom;
            drive_garbage();
            @(negedge clk_i);
            chk("idle_quiet", {bus.cache_re, bus.cache_we, bus.cache_fill, bus.mem_req, bus.cpu_ready}, 0);
        end
    endtask

    // Runs one request; abort_at >= 0 stops after that many cycles without checking the outcome.
    task automatic run_txn(input txn_t t, input int abort_at);
        int c, lk, wait_cnt, ready_c, wb_c, fc_c, fill_c, rep_c, bad;
        int exp_ready, exp_wb, exp_fc, exp_fill;
        logic pend, got_ready, err_o, exp_err, to;
        logic [31:0] rdata_o, exp_rdata;
        c = 0; lk = 0; wait_cnt = 0; ready_c = -1; wb_c = 0; fc_c = 0; fill_c = 0; rep_c = 0; bad = 0;
        pend = 1'b0; got_ready = 1'b0; err_o = 1'b0; rdata_o = '0;
        while (!got_ready && c < BUDGET && c != abort_at) begin
            @(posedge clk_i); #1;
            bus.cpu_valid = 1'b1;
            bus.cpu_we    = t.we;
            bus.cpu_addr  = t.addr;
            bus.cpu_wdata = t.wdata;
            drive_garbage();
            if (pend) begin
                bus.cache_miss   = (lk == 1) ? !t.hit : !t.replay_hit;
                bus.cache_rdata  = (lk == 1) ? t.rd1 : t.rd2;
                bus.victim_dirty = t.dirty;
                bus.victim_tag   = t.vtag;
                bus.victim_line  = t.vline;
            end
            pend = 1'b0;
            @(negedge clk_i);
            if (int'(bus.cache_re) + int'(bus.cache_we) + int'(bus.cache_fill) > 1) bad++;
            if (bus.cache_re || bus.cache_we) begin
                if (bus.cache_we !== t.we || bus.cache_addr !== t.addr ||
                    (t.we && bus.cache_wdata !== t.wdata)) bad++;
                if (c > 0) rep_c++;
                lk++;
                pend = 1'b1;
            end
            if (bus.cache_fill) begin
                fill_c++;
                if (bus.cache_addr !== t.addr || bus.cache_fill_data !== t.line) bad++;
            end
            if (bus.mem_req) begin
                if (bus.mem_we) begin
                    wb_c++;
                    if (fc_c > 0) bad++;
                    if (bus.mem_addr !== {t.vtag, t.addr[7:5], 5'b0} || bus.mem_wdata !== t.vline) bad++;
                end else begin
                    fc_c++;
                    if (bus.mem_addr !== {t.addr[31:5], 5'b0}) bad++;
                end
                wait_cnt++;
                if (wait_cnt == (bus.mem_we ? t.wb_delay : t.fetch_delay) + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = t.line;
                    wait_cnt      = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            if (bus.cpu_ready) begin
                got_ready = 1'b1;
                ready_c   = c;
                err_o     = bus.cpu_err;
                rdata_o   = bus.cpu_rdata;
            end
            c++;
        end
        if (abort_at < 0) begin
            exp_wb = 0; exp_fc = 0; exp_fill = 0; to = 1'b0;
            exp_err = 1'b0; exp_rdata = t.we ? 32'd0 : t.rd1; exp_ready = 2;
            if (!t.hit) begin
                if (t.dirty) begin
                    if (t.wb_delay >= TIMEOUT) begin exp_wb = TIMEOUT; to = 1'b1; end
                    else exp_wb = t.wb_delay + 1;
                end
                if (!to) begin
                    if (t.fetch_delay >= TIMEOUT) begin exp_fc = TIMEOUT; to = 1'b1; end
                    else exp_fc = t.fetch_delay + 1;
                end
                if (to) begin
                    exp_ready = 2 + exp_wb + exp_fc;
                    exp_err   = 1'b1;
                end else begin
                    exp_ready = 2 + exp_wb + exp_fc + 3;
                    exp_fill  = 1;
                    exp_err   = !t.replay_hit;
                    exp_rdata = t.we ? 32'd0 : t.rd2;
                end
            end
            chk("completed", got_ready, 1);
            chk("ready_cycle", ready_c, exp_ready);
            chk("cpu_err", err_o, exp_err);
            if (!exp_err) chk("cpu_rdata", rdata_o, exp_rdata);
            chk("wb_cycles", wb_c, exp_wb);
            chk("fetch_cycles", fc_c, exp_fc);
            chk("fills", fill_c, exp_fill);
            chk("replays", rep_c, exp_fill);
            chk("field_errs", bad, 0);
        end
    endtask

    txn_t t;

    initial begin
        reset_ni      = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        drive_garbage();
        #1;
        chk("reset_outs", any_out(), 0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;

        t = rand_txn(); t.we = 0; t.addr = 32'h0000_0040; t.hit = 1; t.rd1 = 32'hDEAD_BEEF;
        run_txn(t, -1);

        t = rand_txn(); t.we = 0; t.addr = 32'h0000_1020; t.hit = 0; t.dirty = 0;
        t.fetch_delay = 3; t.replay_hit = 1;
        run_txn(t, -1);

        t = rand_txn(); t.we = 1; t.addr = 32'h0000_2064; t.hit = 0; t.dirty = 1;
        t.vtag = 24'h000011; t.replay_hit = 1;
        run_txn(t, -1);

        t = rand_txn(); t.hit = 0; t.dirty = 0; t.fetch_delay = NEVER;
        run_txn(t, -1);

        t = rand_txn(); t.hit = 1; t.we = 0;
        run_txn(t, -1);

        t = rand_txn(); t.hit = 0; t.dirty = 0; t.fetch_delay = TIMEOUT - 1; t.replay_hit = 1;
        run_txn(t, -1);

        t = rand_txn(); t.hit = 0; t.dirty = 1; t.wb_delay = NEVER;
        run_txn(t, -1);

        t = rand_txn(); t.hit = 0; t.dirty = 0; t.replay_hit = 0;
        run_txn(t, -1);

        idle(2);
        t = rand_txn(); t.hit = 0; t.dirty = 1; t.wb_delay = NEVER;
        run_txn(t, 12);
        chk("prewb_mem_req", bus.mem_req, 1);
        #2;
        bus.cpu_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        reset_ni      = 1'b0;
        #1;
        chk("rstwb_mem_req", bus.mem_req, 0);
        chk("rstwb_outs", any_out(), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        t = rand_txn(); t.hit = 1;
        run_txn(t, -1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            t = rand_txn();
            run_txn(t, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
